// File: rtl/sc_tx_port_arbiter.sv
// sc_tx_port_arbiter
// Shares the single Tx engine port among NUM_REQ requesters using a
// Req/Gnt/Rdy/WEn handshake. Grants are registered. Every change of owner
// passes through a GAP cycle, so the outgoing and incoming owners can never
// both drive the Tx engine. The granted requester's write is muxed onto the
// engine combinationally. Handshake violations raise a registered one-cycle
// protocol_err pulse.
module sc_tx_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter bit RR_EN   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rdy,
  input  logic [NUM_REQ-1:0]     wen_in,
  input  logic [8*NUM_REQ-1:0]   cntl_in,
  input  logic [8*NUM_REQ-1:0]   data_in,
  input  logic                   tx_rdy_in,
  output logic                   tx_wen,
  output logic [7:0]             tx_cntl,
  output logic [7:0]             tx_data,
  output logic                   protocol_err
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   winner;
  logic            errDet;

  // Round-robin starts the search one past the previous winner.
  // Fixed priority always starts the search at index 0.
  function automatic logic [IW-1:0] pickWinner(input logic [NUM_REQ-1:0] r,
                                               input logic [IW-1:0]      l);
    logic [IW-1:0]      w;
    logic               found;
    logic [NUM_REQ-1:0] shifted;
    int                 base;
    int                 idx;
    w     = '0;
    found = 1'b0;
    base  = RR_EN ? (int'(l) + 1) : 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx     = (base + i) % NUM_REQ;
      shifted = r >> idx;
      if (!found && shifted[0]) begin
        w     = IW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  // Winner of the current request set; it is used only when the FSM is in IDLE.
  always_comb begin
    winner = pickWinner(req, last);
  end

  // Mux the granted requester onto the Tx engine. gnt is one-hot or zero, so
  // an OR-mux is enough. With no grant, every output stays at zero.
  always_comb begin
    tx_wen  = 1'b0;
    tx_cntl = 8'h00;
    tx_data = 8'h00;
    rdy     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        tx_wen  = tx_wen | wen_in[k];
        tx_cntl = tx_cntl | cntl_in[8*k +: 8];
        tx_data = tx_data | data_in[8*k +: 8];
        rdy[k]  = tx_rdy_in;
      end else begin
        rdy[k]  = 1'b0;
      end
    end
  end

  // Violations:
  //  - a write from a requester that does not hold the grant (the write is dropped);
  //  - a forwarded write while the engine is not ready (the write still goes through).
  always_comb begin
    errDet = (|(wen_in & ~gnt)) | (tx_wen & ~tx_rdy_in);
  end

  // Ownership FSM. It drives the registered grant, the round-robin pointer
  // and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= '0;
      last         <= IW'(NUM_REQ - 1);
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= errDet;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            last  <= winner;
            state <= OWNED;
          end else begin
            state <= IDLE;
          end
        end
        OWNED: begin
          // Any single low sample of the owner's req releases the grant.
          if (!(|(req & gnt))) begin
            gnt   <= '0;
            state <= GAP;
          end else begin
            state <= OWNED;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_tx_port_arbiter.sv
// Testbench for sc_tx_port_arbiter. Two instances share the same inputs:
// one uses round-robin arbitration and the other uses fixed priority.
module tb_sc_tx_port_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  wen_in;
  logic [8*N-1:0] cntl_in;
  logic [8*N-1:0] data_in;
  logic          tx_rdy_in;

  logic [N-1:0]  gntRr, rdyRr, gntFp, rdyFp;
  logic          txWenRr, txWenFp, errRr, errFp;
  logic [7:0]    txCntlRr, txDataRr, txCntlFp, txDataFp;

  int checks = 0;
  int errors = 0;

  // Observations from a contention run: grant order and req-drop-to-gnt delays.
  int cOrd[5];
  int cDly[5];

  // Reference model state for the randomized test. Index 0 is round-robin,
  // index 1 is fixed priority.
  int mOwner[2];
  int mCool[2];
  int mLast[2];
  bit mErr[2];

  always #5 clk = ~clk;

  sc_tx_port_arbiter #(.NUM_REQ(N), .RR_EN(1'b1)) dutRr (
    .clk(clk), .rst(rst), .req(req), .gnt(gntRr), .rdy(rdyRr),
    .wen_in(wen_in), .cntl_in(cntl_in), .data_in(data_in),
    .tx_rdy_in(tx_rdy_in), .tx_wen(txWenRr), .tx_cntl(txCntlRr),
    .tx_data(txDataRr), .protocol_err(errRr)
  );

  sc_tx_port_arbiter #(.NUM_REQ(N), .RR_EN(1'b0)) dutFp (
    .clk(clk), .rst(rst), .req(req), .gnt(gntFp), .rdy(rdyFp),
    .wen_in(wen_in), .cntl_in(cntl_in), .data_in(data_in),
    .tx_rdy_in(tx_rdy_in), .tx_wen(txWenFp), .tx_cntl(txCntlFp),
    .tx_data(txDataFp), .protocol_err(errFp)
  );

  function automatic logic [N-1:0] curGnt(input bit useFp);
    return useFp ? gntFp : gntRr;
  endfunction

  function automatic int gntIndex(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (g == (N'(1) << k)) r = k;
    return r;
  endfunction

  task automatic doReset();
    rst = 1'b1; req = '0; wen_in = '0; tx_rdy_in = 1'b0;
    cntl_in = '0; data_in = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Model: grants come from the spec rules (pick on an idle arbitration
  // cycle, hold while req stays high, one dead cycle after each release).
  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mOwner[d] = -1; mCool[d] = 0; mLast[d] = N - 1; mErr[d] = 1'b0;
    end
  endtask

  task automatic modelStep();
    bit e;
    int w;
    int c;
    for (int d = 0; d < 2; d++) begin
      e = 1'b0;
      for (int k = 0; k < N; k++) if (wen_in[k] && k != mOwner[d]) e = 1'b1;
      if (mOwner[d] >= 0 && wen_in[mOwner[d]] && !tx_rdy_in) e = 1'b1;
      mErr[d] = e;
      if (mOwner[d] >= 0) begin
        if (!req[mOwner[d]]) begin mOwner[d] = -1; mCool[d] = 1; end
      end else if (mCool[d] > 0) begin
        mCool[d] = 0;
      end else if (req != '0) begin
        w = -1;
        if (d == 0) begin
          for (int i = 1; i <= N; i++) begin
            c = (mLast[d] + i) % N;
            if (w < 0 && req[c]) w = c;
          end
        end else begin
          for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
        end
        mOwner[d] = w; mLast[d] = w;
      end
    end
  endtask

  // Every requester asks at once. After 4 grant cycles the owner drops req
  // for one cycle. Once grant g has been released, the bits in perm[g] stay low.
  task automatic runContention(input bit useFp, input logic [N-1:0] p0,
                               input logic [N-1:0] p1, input logic [N-1:0] p2,
                               input logic [N-1:0] p3);
    logic [N-1:0] lowMask;
    logic [N-1:0] perm[5];
    int cnt;
    perm[0] = p0; perm[1] = p1; perm[2] = p2; perm[3] = p3; perm[4] = '0;
    lowMask = '0;
    req = 3'b111;
    for (int g = 0; g < 5; g++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        if (cnt == 1) req = 3'b111 & ~lowMask;
      end while (curGnt(useFp) == '0 && cnt < 8);
      cDly[g] = cnt;
      cOrd[g] = gntIndex(curGnt(useFp));
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        checks++;
        if (curGnt(useFp) !== (N'(1) << cOrd[g])) begin
          errors++;
          $display("FAIL hold_gnt fp=%0d g=%0d got=%b exp=%b", useFp, g,
                   curGnt(useFp), N'(1) << cOrd[g]);
        end
      end
      lowMask = lowMask | perm[g];
      if (cOrd[g] >= 0) req = (3'b111 & ~lowMask) & ~(N'(1) << cOrd[g]);
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (gntRr !== 3'b000 || gntFp !== 3'b000) begin
      errors++; $display("FAIL reset_gnt got=%b/%b exp=000", gntRr, gntFp);
    end
    checks++;
    if (errRr !== 1'b0 || txWenRr !== 1'b0 || txCntlRr !== 8'h00 ||
        txDataRr !== 8'h00 || rdyRr !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs got err=%b wen=%b cntl=%h data=%h rdy=%b exp all 0",
               errRr, txWenRr, txCntlRr, txDataRr, rdyRr);
    end
  endtask

  task automatic test_single();
    doReset();
    req = 3'b010;
    @(negedge clk);
    checks++;
    if (gntRr !== 3'b010) begin errors++; $display("FAIL single_gnt got=%b exp=010", gntRr); end
    tx_rdy_in = 1'b1; #1;
    checks++;
    if (rdyRr !== 3'b010) begin errors++; $display("FAIL single_rdy1 got=%b exp=010", rdyRr); end
    tx_rdy_in = 1'b0; #1;
    checks++;
    if (rdyRr !== 3'b000) begin errors++; $display("FAIL single_rdy0 got=%b exp=000", rdyRr); end
    tx_rdy_in = 1'b1; wen_in = 3'b010;
    cntl_in = 24'h00_05_00; data_in = 24'h00_02_00; #1;
    checks++;
    if (txWenRr !== 1'b1 || txCntlRr !== 8'h05 || txDataRr !== 8'h02) begin
      errors++;
      $display("FAIL single_write got wen=%b cntl=%h data=%h exp 1/05/02",
               txWenRr, txCntlRr, txDataRr);
    end
    @(negedge clk);
    wen_in = '0;
    checks++;
    if (errRr !== 1'b0) begin errors++; $display("FAIL single_noerr got=%b exp=0", errRr); end
    req = '0;
    @(negedge clk);
    checks++;
    if (gntRr !== 3'b000) begin errors++; $display("FAIL single_release got=%b exp=000", gntRr); end
  endtask

  task automatic test_contention_rr();
    int expOrd[5];
    expOrd = '{0, 1, 2, 0, 1};
    doReset();
    runContention(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (cOrd[g] !== expOrd[g]) begin
        errors++; $display("FAIL rr_order g=%0d got=%0d exp=%0d", g, cOrd[g], expOrd[g]);
      end
      checks++;
      if (cDly[g] !== ((g == 0) ? 1 : 3)) begin
        errors++; $display("FAIL rr_delay g=%0d got=%0d exp=%0d", g, cDly[g], (g == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_contention_fp();
    int expOrd[5];
    expOrd = '{0, 0, 0, 1, 2};
    doReset();
    runContention(1'b1, 3'b000, 3'b000, 3'b001, 3'b010);
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (cOrd[g] !== expOrd[g]) begin
        errors++; $display("FAIL fp_order g=%0d got=%0d exp=%0d", g, cOrd[g], expOrd[g]);
      end
      checks++;
      if (cDly[g] !== ((g == 0) ? 1 : 3)) begin
        errors++; $display("FAIL fp_delay g=%0d got=%0d exp=%0d", g, cDly[g], (g == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_violation();
    doReset();
    req = 3'b001;
    @(negedge clk);
    wen_in = 3'b100; tx_rdy_in = 1'b1; #1;
    checks++;
    if (txWenRr !== 1'b0) begin errors++; $display("FAIL viol_drop got=%b exp=0", txWenRr); end
    @(negedge clk);
    wen_in = '0;
    checks++;
    if (errRr !== 1'b1 || errFp !== 1'b1) begin
      errors++; $display("FAIL viol_err got=%b/%b exp=1", errRr, errFp);
    end
    @(negedge clk);
    checks++;
    if (errRr !== 1'b0) begin errors++; $display("FAIL viol_pulse got=%b exp=0", errRr); end
    wen_in = 3'b001; tx_rdy_in = 1'b0; cntl_in = 24'h0000A5; data_in = 24'h00003C; #1;
    checks++;
    if (txWenRr !== 1'b1 || txCntlRr !== 8'hA5 || txDataRr !== 8'h3C) begin
      errors++;
      $display("FAIL notrdy_fwd got wen=%b cntl=%h data=%h exp 1/a5/3c", txWenRr, txCntlRr, txDataRr);
    end
    @(negedge clk);
    wen_in = '0;
    checks++;
    if (errRr !== 1'b1) begin errors++; $display("FAIL notrdy_err got=%b exp=1", errRr); end
    @(negedge clk);
    checks++;
    if (errRr !== 1'b0) begin errors++; $display("FAIL notrdy_pulse got=%b exp=0", errRr); end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    doReset();
    req = 3'b100;
    @(negedge clk);
    wen_in = 3'b100; tx_rdy_in = 1'b1; #1;
    checks++;
    if (gntRr !== 3'b100 || txWenRr !== 1'b1) begin
      errors++; $display("FAIL mid_pre got gnt=%b wen=%b exp 100/1", gntRr, txWenRr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gntRr !== 3'b000 || txWenRr !== 1'b0 || errRr !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got gnt=%b wen=%b err=%b exp 000/0/0", gntRr, txWenRr, errRr);
    end
    rst = 1'b0; wen_in = '0; req = 3'b111;
    @(negedge clk);
    checks++;
    if (gntRr !== 3'b001) begin errors++; $display("FAIL mid_regrant got=%b exp=001", gntRr); end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] eg[2], egd[2], er[2];
    logic [7:0]   ec[2], ed[2];
    logic         ew[2];
    logic [N-1:0] flip;
    int o;
    doReset();
    modelReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        eg[d] = (mOwner[d] >= 0) ? (N'(1) << mOwner[d]) : '0;
        egd[d] = (d == 0) ? gntRr : gntFp;
        checks++;
        if (egd[d] !== eg[d]) begin
          errors++; $display("FAIL rand_gnt cyc=%0d dut=%0d got=%b exp=%b", cyc, d, egd[d], eg[d]);
        end
        checks++;
        if (((d == 0) ? errRr : errFp) !== mErr[d]) begin
          errors++; $display("FAIL rand_err cyc=%0d dut=%0d got=%b exp=%b", cyc, d,
                             (d == 0) ? errRr : errFp, mErr[d]);
        end
      end
      flip = '0;
      for (int k = 0; k < N; k++) begin
        flip[k]   = ($urandom_range(0, 3) == 0);
        wen_in[k] = ($urandom_range(0, 3) == 0);
      end
      req = req ^ flip;
      tx_rdy_in = ($urandom_range(0, 3) != 0);
      cntl_in = 24'($urandom);
      data_in = 24'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        o = mOwner[d];
        ew[d] = (o >= 0) ? wen_in[o] : 1'b0;
        ec[d] = (o >= 0) ? cntl_in[8*o +: 8] : 8'h00;
        ed[d] = (o >= 0) ? data_in[8*o +: 8] : 8'h00;
        er[d] = (o >= 0) ? (N'(tx_rdy_in) << o) : '0;
      end
      checks++;
      if (txWenRr !== ew[0] || txCntlRr !== ec[0] || txDataRr !== ed[0] || rdyRr !== er[0]) begin
        errors++;
        $display("FAIL rand_mux_rr cyc=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", cyc,
                 txWenRr, txCntlRr, txDataRr, rdyRr, ew[0], ec[0], ed[0], er[0]);
      end
      checks++;
      if (txWenFp !== ew[1] || txCntlFp !== ec[1] || txDataFp !== ed[1] || rdyFp !== er[1]) begin
        errors++;
        $display("FAIL rand_mux_fp cyc=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", cyc,
                 txWenFp, txCntlFp, txDataFp, rdyFp, ew[1], ec[1], ed[1], er[1]);
      end
      @(posedge clk);
      modelStep();
    end
    req = '0; wen_in = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; wen_in = '0; tx_rdy_in = 1'b0; cntl_in = '0; data_in = '0;
    test_reset();
    test_single();
    test_contention_rr();
    test_contention_fp();
    test_violation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
